mem_stage: RTL

- Memory stage of the five-stage pipeline; consumes the EX/MEM latch outputs directly.
- Issues data-memory read/write requests and holds the pipeline on a cache miss.
- Resolves branch, jump and jr redirects and tells the fetch stage where to go.
- Owns the MEM/WB latch: selects write-back data, registers it, and carries halt through as sticky.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_ctrl.sv | 91 +++++++++
 rtl/mem_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline: datapath words, register indices,
// the write-back source select and the memory-stage FSM states.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;
  localparam int REG_BITS  = 5;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [REG_BITS-1:0]  regbits_t;

  // Write-back source, encoded to match the Mem control field
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_NPC  = 2'b10,
    WB_EXT  = 2'b11
  } wbsel_t;

  // Memory-stage sequencing: running, waiting on the data cache, halted for good
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    WAIT   = 2'b01,
    HALTED = 2'b10
  } memstate_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data cache (slave).
interface mem_stage_if #(
  parameter int WORD_W = 32
);

  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dload
  );

endinterface

// File: rtl/mem_ctrl.sv
// Memory-stage control: request decode, cache-miss stall, RUN/WAIT/HALTED
// sequencing and the saturating miss-wait counter with its sticky timeout flag.
module mem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      dren_i,
  input  logic      dwen_i,
  input  logic      dhit_i,
  input  logic      halt_i,
  output logic      ren_o,
  output logic      wen_o,
  output logic      stall_o,
  output logic      timeout_o,
  output memstate_t state_o
);

  localparam int              CNT_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  memstate_t        state_r;
  memstate_t        state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             timeout_r;
  logic             req_s;

  // Request decode; a simultaneous load+store is issued as a store only,
  // and nothing is requested while held in reset or after halting
  always_comb begin
    req_s   = (dren_i | dwen_i) & (state_r != HALTED) & ~RST;
    wen_o   = req_s & dwen_i;
    ren_o   = req_s & dren_i & ~dwen_i;
    stall_o = req_s & ~dhit_i;
  end

  // Next state and next wait count; count only advances while still missing in WAIT
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = {CNT_W{1'b0}};
    case (state_r)
      RUN: begin
        if (stall_o) begin
          state_next_s = WAIT;
        end else if (halt_i) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = RUN;
        end
      end
      WAIT: begin
        if (stall_o) begin
          state_next_s = WAIT;
          cnt_next_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (halt_i) begin
          state_next_s = HALTED;
        end else begin
          state_next_s = RUN;
        end
      end
      HALTED: begin
        state_next_s = HALTED;
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  // State, wait counter and sticky timeout registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= RUN;
      cnt_r     <= {CNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if ((state_r == WAIT) && stall_o && (cnt_next_s == CNT_MAX)) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_r;
  assign state_o   = state_r;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives the data-memory bus, resolves control-flow redirects,
// and owns the MEM/WB latch including the sticky halt.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int REG_AW   = 5,
  parameter int WAIT_MAX = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] npc_i,
  input  logic [WORD_W-1:0] Jaddr_i,
  input  logic [WORD_W-1:0] rdat1_i,
  input  logic [WORD_W-1:0] rdat2_i,
  input  logic [WORD_W-1:0] alu_out_i,
  input  logic [WORD_W-1:0] extout_i,
  input  logic [1:0]        Mem_i,
  input  logic              Branch_i,
  input  logic              BNE_i,
  input  logic              zero_i,
  input  logic              jump_i,
  input  logic              jr_i,
  input  logic              DRen_i,
  input  logic              DWen_i,
  input  logic              RegW_i,
  input  logic [REG_AW-1:0] RegDest_i,
  input  logic              halt_i,
  mem_stage_if.master       dbus,
  output logic              stall_o,
  output logic              redirect_o,
  output logic [WORD_W-1:0] pc_target_o,
  output logic              wb_wen_o,
  output logic [REG_AW-1:0] wb_sel_o,
  output logic [WORD_W-1:0] wb_wdat_o,
  output logic              halt_o,
  output logic              timeout_o
);

  memstate_t         state_s;
  logic              ren_s;
  logic              wen_s;
  logic              stall_s;
  logic              active_s;
  logic              taken_s;
  logic              redirect_s;
  logic [WORD_W-1:0] target_s;
  logic [WORD_W-1:0] wdat_s;

  logic              wb_wen_r;
  logic [REG_AW-1:0] wb_sel_r;
  logic [WORD_W-1:0] wb_wdat_r;
  logic              halt_r;

  mem_ctrl #(
    .WAIT_MAX (WAIT_MAX)
  ) u_ctrl (
    .CLK       (CLK),
    .RST       (RST),
    .dren_i    (DRen_i),
    .dwen_i    (DWen_i),
    .dhit_i    (dbus.dhit),
    .halt_i    (halt_i),
    .ren_o     (ren_s),
    .wen_o     (wen_s),
    .stall_o   (stall_s),
    .timeout_o (timeout_o),
    .state_o   (state_s)
  );

  assign dbus.dmemREN   = ren_s;
  assign dbus.dmemWEN   = wen_s;
  assign dbus.dmemaddr  = alu_out_i;
  assign dbus.dmemstore = rdat2_i;
  assign stall_o        = stall_s;

  // Redirect resolution; only an unstalled instruction redirects, so each fires once
  always_comb begin
    active_s   = ~stall_s & (state_s != HALTED) & ~RST;
    taken_s    = Branch_i & (zero_i ^ BNE_i);
    redirect_s = 1'b0;
    target_s   = {WORD_W{1'b0}};
    if (active_s) begin
      if (jr_i) begin
        redirect_s = 1'b1;
        target_s   = rdat1_i;
      end else if (jump_i) begin
        redirect_s = 1'b1;
        target_s   = Jaddr_i;
      end else if (taken_s) begin
        redirect_s = 1'b1;
        target_s   = npc_i + (extout_i << 2);
      end else begin
        redirect_s = 1'b0;
        target_s   = {WORD_W{1'b0}};
      end
    end else begin
      redirect_s = 1'b0;
      target_s   = {WORD_W{1'b0}};
    end
  end

  assign redirect_o  = redirect_s;
  assign pc_target_o = target_s;

  // Write-back source select; load data is taken on the dhit cycle itself
  always_comb begin
    wdat_s = alu_out_i;
    case (wbsel_t'(Mem_i))
      WB_ALU:  wdat_s = alu_out_i;
      WB_LOAD: wdat_s = dbus.dload;
      WB_NPC:  wdat_s = npc_i;
      WB_EXT:  wdat_s = extout_i;
      default: wdat_s = alu_out_i;
    endcase
  end

  // MEM/WB latch: bubbles while stalled or halted so nothing writes twice; halt is sticky
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_wen_r  <= 1'b0;
      wb_sel_r  <= {REG_AW{1'b0}};
      wb_wdat_r <= {WORD_W{1'b0}};
      halt_r    <= 1'b0;
    end else begin
      if (stall_s || (state_s == HALTED)) begin
        wb_wen_r  <= 1'b0;
        wb_sel_r  <= {REG_AW{1'b0}};
        wb_wdat_r <= {WORD_W{1'b0}};
      end else begin
        wb_wen_r  <= RegW_i & (RegDest_i != {REG_AW{1'b0}});
        wb_sel_r  <= RegDest_i;
        wb_wdat_r <= wdat_s;
      end
      halt_r <= halt_r | (halt_i & ~stall_s);
    end
  end

  assign wb_wen_o  = wb_wen_r;
  assign wb_sel_o  = wb_sel_r;
  assign wb_wdat_o = wb_wdat_r;
  assign halt_o    = halt_r;

endmodule
